ram2x2_access_ctrl: RTL
=======================

Name: ram2x2_access_ctrl

Overview:
Initiator-side controller for the 2x2-bit dual-read register-file RAM. It accepts host read/write requests over a valid/ready handshake and drives the RAM's write and read ports. It captures read data and returns one response per request over a second valid/ready handshake. After reset it sweeps every RAM row to a known value before accepting requests. It sits between a host/datapath sequencer and the RAM instance.

Parameters:
DATA_W, 2, width of one RAM word
ADDR_W, 1, RAM address width; DEPTH = 2**ADDR_W rows
INIT_VALUE, 2'b00, word written to every row during the post-reset sweep (width DATA_W)

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write, 0 = dual read
req_addr  in  ADDR_W  write address, or port-1 read address
req_addr_b  in  ADDR_W  port-2 read address (ignored on write)
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_write  out  1  response belongs to a write (ack)
rsp_rdata_1  out  DATA_W  port-1 read data (0 for write acks)
rsp_rdata_2  out  DATA_W  port-2 read data (0 for write acks)
rsp_err  out  1  write-verify mismatch (see Optional Feature)
busy  out  1  high in any state except IDLE
ram_write_data  out  DATA_W  to RAM Write_Data
ram_write_address  out  ADDR_W  to RAM Write_Address
ram_write_enable  out  1  to RAM Write_Enable
ram_read_address_1  out  ADDR_W  to RAM Read_Address_1
ram_read_address_2  out  ADDR_W  to RAM Read_Address_2
ram_read_data_1  in  DATA_W  from RAM Read_Data_1 (combinational read)
ram_read_data_2  in  DATA_W  from RAM Read_Data_2

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is synchronous and active-high.
- FSM states are INIT, IDLE, WRITE, READ, VERIFY and RESP. The state register is the only control state; RAM port outputs are decoded from registered state, address and data.
- Reset values: state=INIT, init_ptr=0, req_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata_1/2=0, rsp_err=0, busy=1.
- While reset is high, ram_write_enable is forced 0.
- Reset in any state, including mid-response, abandons the operation. The pending response is dropped with no handshake.
- INIT state:
  - Drives ram_write_enable=1, ram_write_address=init_ptr, ram_write_data=INIT_VALUE.
  - init_ptr increments each cycle.
  - When init_ptr==DEPTH-1, the next state is IDLE. The sweep takes exactly DEPTH cycles after reset deasserts.
- IDLE state:
  - req_ready=1 and ram_write_enable=0. Only IDLE asserts req_ready.
  - On req_valid&&req_ready, capture write flag, addresses and data.
  - Go to WRITE if req_write=1, else READ.
- WRITE state:
  - ram_write_enable=1 with the captured address and data for exactly one cycle. The RAM updates on the closing edge.
  - Next state is VERIFY if the feature is enabled, else RESP.
  - Response fields: rsp_write=1, rsp_rdata_1/2=0.
- READ state:
  - ram_read_address_1=captured req_addr, ram_read_address_2=captured req_addr_b.
  - Register ram_read_data_1/2 into rsp_rdata_1/2 at the end of the cycle, with rsp_write=0.
  - Next state is RESP.
- RESP state:
  - rsp_valid=1 with rsp_* held stable until rsp_ready. On the handshake, go to IDLE.
  - Back-to-back requests: req_ready rises the cycle after the response handshake.
- Latency: a request accepted at edge N gives rsp_valid high after edge N+2 (N+3 with verify on writes). Minimum throughput is one request per 3 cycles.
- Address range: addresses are ADDR_W wide, so every value is a legal row and no wrap or error handling is needed.
- Read of the address just written: the write has completed before READ, so new data is returned.
- Outside READ and VERIFY, read addresses hold their last value. Outside WRITE and INIT, ram_write_enable=0.

Optional Feature:
- Macro RAM_CTRL_WRITE_VERIFY_EN.
- Defined:
  - After WRITE, the VERIFY state drives ram_read_address_2=captured address.
  - It compares ram_read_data_2 to the captured wdata and registers rsp_err=(mismatch).
  - Next state is RESP.
- Undefined:
  - The VERIFY state is not built and WRITE goes directly to RESP.
  - rsp_err is tied 0.

Decomposition:
- Package ram_ctrl_pkg holds:
  - the state enum (INIT, IDLE, WRITE, READ, VERIFY, RESP);
  - default DATA_W/ADDR_W constants;
  - a default INIT_VALUE.
- No sub-module is natural: one FSM with capture registers fits in one module. The RAM is instantiated alongside it by the parent and the bench, not inside it.

Test Plan:
- Init sweep: DATA_W=2, INIT_VALUE=2'b10; release reset -> write_enable high 2 cycles at addr 0 then 1, data 2'b10. Then req_ready=1, and a dual read (0,1) returns 2'b10/2'b10.
- Write then read: write addr1=2'b01, then read (1,0) -> write ack rsp_write=1 at accept+2; read gives rsp_rdata_1=2'b01, rsp_rdata_2=INIT_VALUE.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and data stay stable, req_ready stays 0, and no RAM write occurs.
- Reset mid-op: assert reset in RESP -> rsp_valid=0 next cycle. Then a full 2-cycle INIT sweep runs and previously written data reads back as INIT_VALUE.
- Verify (macro defined): bench RAM model forces row 0 bit stuck at 0; write 2'b11 to addr 0 -> rsp_err=1 at accept+3. A clean write of 2'b00 gives rsp_err=0.
- Back-to-back: four requests with req_valid held and rsp_ready=1 -> accepts spaced exactly 3 cycles (4 with verify writes), responses in order.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the 2x2 register-file RAM access controller.
// Holds the controller FSM state encoding and default geometry / sweep value.
// No logic; imported by the controller and anything that instantiates it.
package ram_ctrl_pkg;

    // Default RAM geometry: 2-bit words, 1-bit address (2 rows).
    localparam int DEF_DATA_W = 2;
    localparam int DEF_ADDR_W = 1;

    // Word written to every row by the post-reset sweep.
    localparam logic [DEF_DATA_W-1:0] DEF_INIT_VALUE = 2'b00;

    // Controller FSM states. VERIFY is only reachable when write-verify is built.
    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        VERIFY = 3'd4,
        RESP   = 3'd5
    } state_e;

    // Number of rows for a given address width.
    function automatic int rows_for(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/ram2x2_access_ctrl.sv
// Initiator-side controller for the 2x2 dual-read RAM; sweeps rows after reset, then serves host requests.
// Latency: request accepted in cycle N -> rsp_valid in cycle N+2 (N+3 for writes with verify); one request per 3+ cycles.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready. Optional macro RAM_CTRL_WRITE_VERIFY_EN.
module ram2x2_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter int                 ADDR_W     = DEF_ADDR_W,
    parameter logic [DATA_W-1:0]  INIT_VALUE = DATA_W'(DEF_INIT_VALUE)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata_1,
    output logic [DATA_W-1:0] rsp_rdata_2,
    output logic              rsp_err,

    output logic              busy,

    output logic [DATA_W-1:0] ram_write_data,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_read_address_1,
    output logic [ADDR_W-1:0] ram_read_address_2,
    input  logic [DATA_W-1:0] ram_read_data_1,
    input  logic [DATA_W-1:0] ram_read_data_2
);

    localparam int                DEPTH    = rows_for(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;

    // Request capture registers, loaded on the IDLE handshake.
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] wdata_q;

    // Read addresses keep their last driven value outside READ/VERIFY.
    logic [ADDR_W-1:0] rd_addr_1_q;
    logic [ADDR_W-1:0] rd_addr_2_q;

    // Response registers, stable for the whole RESP state.
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_1_q;
    logic [DATA_W-1:0] rsp_rdata_2_q;

    logic              accept;
    assign accept = req_valid && req_ready;

    // State and sweep-pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Next-state logic: sweep, accept, one-cycle RAM access, then hold response.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + ADDR_W'(1);
                if (init_ptr_q == LAST_ROW) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    state_d = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
`ifdef RAM_CTRL_WRITE_VERIFY_EN
                state_d = VERIFY;
`else
                state_d = RESP;
`endif
            end
            READ: begin
                state_d = RESP;
            end
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            VERIFY: begin
                state_d = RESP;
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Capture the request fields on the accept handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            addr_b_q <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            addr_q   <= req_addr;
            addr_b_q <= req_addr_b;
            wdata_q  <= req_wdata;
        end
    end

    // Remember the read addresses last presented to the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_1_q <= '0;
            rd_addr_2_q <= '0;
        end else if (state_q == READ) begin
            rd_addr_1_q <= addr_q;
            rd_addr_2_q <= addr_b_q;
        end else if (state_q == VERIFY) begin
            rd_addr_2_q <= addr_q;
        end
    end

    // Build the response: write acks carry zero data, reads sample the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_write_q   <= 1'b0;
            rsp_rdata_1_q <= '0;
            rsp_rdata_2_q <= '0;
        end else if (state_q == WRITE) begin
            rsp_write_q   <= 1'b1;
            rsp_rdata_1_q <= '0;
            rsp_rdata_2_q <= '0;
        end else if (state_q == READ) begin
            rsp_write_q   <= 1'b0;
            rsp_rdata_1_q <= ram_read_data_1;
            rsp_rdata_2_q <= ram_read_data_2;
        end
    end

`ifdef RAM_CTRL_WRITE_VERIFY_EN
    logic rsp_err_q;

    // Read back the row just written on port 2 and flag any difference.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
        end else if (state_q == WRITE || state_q == READ) begin
            rsp_err_q <= 1'b0;
        end else if (state_q == VERIFY) begin
            rsp_err_q <= (ram_read_data_2 != wdata_q);
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Decode host handshake and RAM port drives from registered state.
    always_comb begin
        req_ready          = (state_q == IDLE);
        rsp_valid          = (state_q == RESP);
        busy               = (state_q != IDLE);
        rsp_write          = rsp_write_q;
        rsp_rdata_1        = rsp_rdata_1_q;
        rsp_rdata_2        = rsp_rdata_2_q;
        ram_write_enable   = 1'b0;
        ram_write_address  = addr_q;
        ram_write_data     = wdata_q;
        ram_read_address_1 = rd_addr_1_q;
        ram_read_address_2 = rd_addr_2_q;
        case (state_q)
            INIT: begin
                ram_write_enable  = !reset;
                ram_write_address = init_ptr_q;
                ram_write_data    = INIT_VALUE;
            end
            WRITE: begin
                ram_write_enable  = !reset;
            end
            READ: begin
                ram_read_address_1 = addr_q;
                ram_read_address_2 = addr_b_q;
            end
            VERIFY: begin
                ram_read_address_2 = addr_q;
            end
            default: begin
            end
        endcase
    end

endmodule
